// File: rtl/mem_access_stage.sv
// Memory stage: lane-aligned data-memory port, load extension, wait/timeout FSM and M/W register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being forced aligned.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_index,
    input  logic [3:0]  dm_w_en,
    input  logic        wb_sel,
    input  logic        wb_en,
    input  logic [2:0]  func3,
    input  logic        ecall_sig,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        stall_m,
    output logic [31:0] wb_data_reg,
    output logic [4:0]  rd_index_reg,
    output logic        wb_en_reg,
    output logic        ecall_sig_reg,
    output logic        bus_err
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_rd_index;
    logic             r_wb_en, r_ecall, r_bus_err;

    logic        w_mem_op, w_is_store, w_is_byte, w_is_half, w_is_word;
    logic        w_misal, w_timeout_hit, w_req, w_done;
    logic [1:0]  w_off;
    logic [31:0] w_byte_sh, w_half_sh, w_load_ext;

    assign w_mem_op   = wb_sel | (dm_w_en != 4'b0000);
    assign w_is_store = (dm_w_en != 4'b0000);

    // Access size comes from the byte mask for stores and from func3 for loads.
    always_comb begin
        if (w_is_store) begin
            w_is_byte = (dm_w_en == 4'b0001);
            w_is_half = (dm_w_en == 4'b0011);
        end else begin
            w_is_byte = (func3[1:0] == 2'b00);
            w_is_half = (func3[1:0] == 2'b01);
        end
        w_is_word = ~w_is_byte & ~w_is_half;
    end

    assign w_off = w_is_byte ? alu_out[1:0] :
                   w_is_half ? {alu_out[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misal = w_mem_op & ((w_is_half & alu_out[0]) | (w_is_word & (alu_out[1:0] != 2'b00)));
`else
    assign w_misal = 1'b0;
`endif

    assign w_timeout_hit = (r_state == ST_WAIT) & w_mem_op & ~dm_ready
                         & (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_req  = w_mem_op & ~w_misal & ~w_timeout_hit;
    assign w_done = w_req & dm_ready;

    assign dm_req   = w_req;
    assign dm_addr  = {alu_out[31:2], 2'b00};
    assign dm_we    = w_is_store ? (dm_w_en << w_off) : 4'b0000;
    assign dm_wdata = rs2_data << {w_off, 3'b000};
    assign stall_m  = w_req & ~dm_ready;

    always_comb begin
        w_byte_sh = dm_rdata >> {w_off, 3'b000};
        w_half_sh = dm_rdata >> {w_off[1], 4'b0000};
        case (func3)
            3'b000:  w_load_ext = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'b001:  w_load_ext = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'b100:  w_load_ext = {24'b0, w_byte_sh[7:0]};
            3'b101:  w_load_ext = {16'b0, w_half_sh[15:0]};
            default: w_load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (~w_mem_op | w_misal | dm_ready | w_timeout_hit) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_W'(1);
        end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wb_data  <= '0;
            r_rd_index <= '0;
            r_wb_en    <= 1'b0;
            r_ecall    <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (~w_mem_op | w_done) begin
                r_wb_data  <= wb_sel ? w_load_ext : alu_out;
                r_rd_index <= rd_index;
                r_wb_en    <= wb_en;
                r_ecall    <= ecall_sig;
                r_bus_err  <= 1'b0;
            end else begin
                // Stall, timeout and misalign trap all retire as a bubble.
                r_wb_en    <= 1'b0;
                r_ecall    <= 1'b0;
                r_bus_err  <= w_timeout_hit | w_misal;
            end
        end
    end

    assign wb_data_reg   = r_wb_data;
    assign rd_index_reg  = r_rd_index;
    assign wb_en_reg     = r_wb_en;
    assign ecall_sig_reg = r_ecall;
    assign bus_err       = r_bus_err;
endmodule
